// File: rtl/gomoku_pkg.sv
// Shared definitions for the Gomoku win checker: cell encodings, scan directions,
// FSM states and default board geometry.
package gomoku_pkg;

  localparam int DEF_BOARD_N = 10;
  localparam int DEF_WIN_LEN = 5;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b10;
  localparam logic [1:0] CELL_WHITE = 2'b11;

  typedef enum logic [1:0] {
    DIR_H  = 2'd0,
    DIR_V  = 2'd1,
    DIR_DR = 2'd2,
    DIR_DL = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WALK_POS = 3'd1,
    ST_WALK_NEG = 3'd2,
    ST_NEXT_DIR = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

endpackage

// File: rtl/gomoku_cell_step.sv
// Combinational neighbour locator: the cell 'distance' steps from (row, col) along
// dir (negated when sign=1), with an on-board flag; columns never wrap into rows.
module gomoku_cell_step
  import gomoku_pkg::*;
#(
  parameter int BOARD_N = DEF_BOARD_N,
  parameter int POS_W   = 8,
  parameter int RC_W    = 4,
  parameter int CNT_W   = 4
) (
  input  logic [RC_W-1:0]  row,
  input  logic [RC_W-1:0]  col,
  input  dir_e             dir,
  input  logic             sign,
  input  logic [CNT_W-1:0] distance,
  output logic             on_board,
  output logic [POS_W-1:0] nb_idx
);

  int dr_s;
  int dc_s;
  int r_s;
  int c_s;

  // Signed row/col offsets per axis, then bounds check against the board edges
  always_comb begin
    dr_s = 32'sd0;
    dc_s = 32'sd0;
    case (dir)
      DIR_H:   begin dr_s = 32'sd0; dc_s = 32'sd1;  end
      DIR_V:   begin dr_s = 32'sd1; dc_s = 32'sd0;  end
      DIR_DR:  begin dr_s = 32'sd1; dc_s = 32'sd1;  end
      DIR_DL:  begin dr_s = 32'sd1; dc_s = -32'sd1; end
      default: begin dr_s = 32'sd0; dc_s = 32'sd0;  end
    endcase
    dr_s = sign ? -dr_s : dr_s;
    dc_s = sign ? -dc_s : dc_s;
    r_s = int'(row) + dr_s * int'(distance);
    c_s = int'(col) + dc_s * int'(distance);
    on_board = (r_s >= 32'sd0) && (r_s < BOARD_N) && (c_s >= 32'sd0) && (c_s < BOARD_N);
    if (on_board) begin
      nb_idx = POS_W'(r_s * BOARD_N + c_s);
    end else begin
      nb_idx = '0;
    end
  end

endmodule

// File: rtl/gomoku_win_checker.sv
// Sequential five-in-a-row detector: walks 4 axes from the placed stone, one cell per clock.
// Define GOMOKU_EXACT_LEN_EN for the exact-length rule (overlines do not win).
module gomoku_win_checker
  import gomoku_pkg::*;
#(
  parameter int BOARD_N = DEF_BOARD_N,
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int POS_W   = 8,
  parameter int CNT_W   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [POS_W-1:0]             pos,
  input  logic [1:0]                   colour,
  input  logic [2*BOARD_N*BOARD_N-1:0] board_state,
  input  logic                         clear,
  output logic                         busy,
  output logic                         done,
  output logic                         win,
  output logic [1:0]                   win_dir,
  output logic [CNT_W-1:0]             run_len,
  output logic                         bad_pos,
  output logic                         game_over,
  output logic [1:0]                   winner
);

  localparam int CELLS = BOARD_N * BOARD_N;
  localparam int RC_W  = (BOARD_N > 1) ? $clog2(BOARD_N) : 1;
  localparam int BS_W  = $clog2(2 * CELLS);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_e            state_r, state_n;
  dir_e              dir_r, win_dir_r;
  logic [RC_W-1:0]   row_r, col_r;
  logic [1:0]        colour_r, winner_r;
  logic [CNT_W-1:0]  count_r, dist_r, run_len_r;
  logic              busy_r, done_r, win_r, bad_pos_r, game_over_r;
  logic              on_board_s, start_ok_s, pos_bad_s, step_s, win_hit_s;
  logic [POS_W-1:0]  nb_idx_s;
  logic [BS_W-1:0]   bit_idx_s;
  logic [1:0]        cell_s;

  gomoku_cell_step #(
    .BOARD_N(BOARD_N), .POS_W(POS_W), .RC_W(RC_W), .CNT_W(CNT_W)
  ) u_step (
    .row(row_r), .col(col_r), .dir(dir_r), .sign(state_r == ST_WALK_NEG),
    .distance(dist_r), .on_board(on_board_s), .nb_idx(nb_idx_s)
  );

  assign bit_idx_s  = BS_W'({nb_idx_s, 1'b0});
  assign cell_s     = board_state[bit_idx_s +: 2];
  assign start_ok_s = (state_r == ST_IDLE) && start && !game_over_r;
  assign pos_bad_s  = (int'(pos) >= CELLS);

  // A half-ray continues while the probed cell matches and the match cap is not reached
`ifdef GOMOKU_EXACT_LEN_EN
  assign step_s    = on_board_s && (cell_s == colour_r) && (int'(dist_r) <= WIN_LEN);
  assign win_hit_s = (int'(count_r) == WIN_LEN);
`else
  assign step_s    = on_board_s && (cell_s == colour_r) && (int'(dist_r) <= WIN_LEN - 1);
  assign win_hit_s = (int'(count_r) >= WIN_LEN);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_n = pos_bad_s ? ST_DONE : ST_WALK_POS;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_WALK_POS: state_n = step_s ? ST_WALK_POS : ST_WALK_NEG;
      ST_WALK_NEG: state_n = step_s ? ST_WALK_NEG : ST_NEXT_DIR;
      ST_NEXT_DIR: state_n = (win_hit_s || dir_r == DIR_DL) ? ST_DONE : ST_WALK_POS;
      ST_DONE:     state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
  end

  // Scan datapath: origin latch, walk distance, run count and per-scan results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_r     <= DIR_H;
      row_r     <= '0;
      col_r     <= '0;
      colour_r  <= 2'b00;
      count_r   <= '0;
      dist_r    <= '0;
      win_r     <= 1'b0;
      win_dir_r <= DIR_H;
      run_len_r <= '0;
      bad_pos_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_ok_s) begin
            row_r     <= RC_W'(int'(pos) / BOARD_N);
            col_r     <= RC_W'(int'(pos) % BOARD_N);
            colour_r  <= colour;
            dir_r     <= DIR_H;
            count_r   <= ONE_C;
            dist_r    <= ONE_C;
            win_r     <= 1'b0;
            win_dir_r <= DIR_H;
            run_len_r <= '0;
            bad_pos_r <= pos_bad_s;
          end
        end
        ST_WALK_POS, ST_WALK_NEG: begin
          if (step_s) begin
            count_r <= count_r + ONE_C;
            dist_r  <= dist_r + ONE_C;
          end else begin
            dist_r  <= ONE_C;
          end
        end
        ST_NEXT_DIR: begin
          if (count_r > run_len_r) begin
            run_len_r <= count_r;
          end
          if (win_hit_s) begin
            win_r     <= 1'b1;
            win_dir_r <= dir_r;
          end else if (dir_r != DIR_DL) begin
            dir_r   <= dir_e'(dir_r + 2'd1);
            count_r <= ONE_C;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky game-over; a win leaving DONE takes priority over a coincident clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      game_over_r <= 1'b0;
      winner_r    <= 2'b00;
    end else if (state_r == ST_DONE && win_r) begin
      game_over_r <= 1'b1;
      winner_r    <= colour_r;
    end else if (clear) begin
      game_over_r <= 1'b0;
      winner_r    <= 2'b00;
    end
  end

  // busy/done decoded from the next state so they align with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_n == ST_WALK_POS) || (state_n == ST_WALK_NEG) || (state_n == ST_NEXT_DIR);
      done_r <= (state_n == ST_DONE);
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign win       = win_r;
  assign win_dir   = win_dir_r;
  assign run_len   = run_len_r;
  assign bad_pos   = bad_pos_r;
  assign game_over = game_over_r;
  assign winner    = winner_r;

endmodule
